// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: opcodes, FSM states,
// datapath mux encodings and instruction classification helpers.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] RD_SEL_MEM    = 2'd0;
    localparam logic [1:0] RD_SEL_IMM    = 2'd1;
    localparam logic [1:0] RD_SEL_ALU    = 2'd2;
    localparam logic [1:0] RD_SEL_PC_INC = 2'd3;

    localparam logic [2:0] FUNC_ADD = 3'b000;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_LOAD_IR,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
`ifdef CTRL_ILLEGAL_TRAP_EN
        ST_WB,
        ST_HALT
`else
        ST_WB
`endif
    } state_t;

    typedef enum logic [3:0] {
        CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
        CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_NOP, CLS_ILLEGAL
    } insn_class_t;

    function automatic insn_class_t decode_class(input logic [31:0] insn);
        insn_class_t cls;
        case (insn[6:0])
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            // funct3 010/011 have no branch meaning
            OPC_BRANCH: cls = (insn[14:13] == 2'b01) ? CLS_ILLEGAL : CLS_BRANCH;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_OP_IMM: cls = CLS_OP_IMM;
            OPC_OP:     cls = CLS_OP;
            OPC_FENCE,
            OPC_SYSTEM: cls = CLS_NOP;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                          input logic ls, input logic lu);
        logic base;
        case (funct3[2:1])
            2'b00:   base = eq;
            2'b10:   base = ls;
            2'b11:   base = lu;
            default: base = 1'b0;
        endcase
        return base ^ funct3[0];
    endfunction

endpackage

// File: rtl/control_unit_imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J format from the
// opcode and sign-extends to 32 bits.
import ctrl_pkg::*;

module imm_gen (
    input  logic [31:0] insn,
    output logic [31:0] imm
);

    always_comb begin
        imm = {{20{insn[31]}}, insn[31:20]};
        case (insn[6:0])
            OPC_STORE:  imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            OPC_BRANCH: imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            OPC_LUI,
            OPC_AUIPC:  imm = {insn[31:12], 12'b0};
            OPC_JAL:    imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default:    imm = {{20{insn[31]}}, insn[31:20]};
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I control FSM: FETCH, LOAD_IR, DECODE, EXEC, [MEM], WB.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions instead of NOPing.
import ctrl_pkg::*;

module control_unit (
    input  logic        clk,
    input  logic        rs_i,
    input  logic [31:0] insn,
    input  logic        EQ,
    input  logic        LS,
    input  logic        LU,
    output logic        insn_clk,
    output logic        pc_clk,
    output logic        rd_clk,
    output logic        mem_we,
    output logic        pc_next_sel,
    output logic        pc_alu_sel,
    output logic        alu_sel_a,
    output logic        alu_sel_b,
    output logic        addr_sel,
    output logic [1:0]  rd_sel,
    output logic [2:0]  func,
    output logic [2:0]  mem_size,
    output logic        sub_sra,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        halted
);

    state_t      state_q, state_d;
    logic        insn_clk_q, insn_clk_d;
    logic        pc_clk_q, pc_clk_d;
    logic        rd_clk_q, rd_clk_d;
    logic        mem_we_q, mem_we_d;
    insn_class_t cls;
    logic        writes_rd;
    logic        active;

    assign cls      = decode_class(insn);
    assign rs1      = insn[19:15];
    assign rs2      = insn[24:20];
    assign rd       = insn[11:7];
    assign mem_size = insn[14:12];

    imm_gen u_imm_gen (
        .insn (insn),
        .imm  (imm)
    );

    always_comb begin
        writes_rd = 1'b0;
        case (cls)
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
            CLS_LOAD, CLS_OP_IMM, CLS_OP: writes_rd = 1'b1;
            default:                      writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:   state_d = ST_LOAD_IR;
            ST_LOAD_IR: state_d = ST_DECODE;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_DECODE:  state_d = (cls == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
            ST_HALT:    state_d = ST_HALT;
`else
            ST_DECODE:  state_d = ST_EXEC;
`endif
            ST_EXEC:    state_d = (cls == CLS_LOAD) ? ST_MEM : ST_WB;
            ST_MEM:     state_d = ST_WB;
            ST_WB:      state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    // Strobes are registered versions of "entering this state", so each is a
    // clean flop output lasting exactly one cycle.
    always_comb begin
        insn_clk_d = (state_d == ST_LOAD_IR);
        pc_clk_d   = (state_d == ST_WB);
        rd_clk_d   = (state_d == ST_WB) && writes_rd && (insn[11:7] != 5'd0);
        mem_we_d   = (state_d == ST_EXEC) && (cls == CLS_STORE);
    end

    always_ff @(posedge clk) begin
        if (rs_i) begin
            state_q    <= ST_FETCH;
            insn_clk_q <= 1'b0;
            pc_clk_q   <= 1'b0;
            rd_clk_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            insn_clk_q <= insn_clk_d;
            pc_clk_q   <= pc_clk_d;
            rd_clk_q   <= rd_clk_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign insn_clk = insn_clk_q;
    assign pc_clk   = pc_clk_q;
    assign rd_clk   = rd_clk_q;
    assign mem_we   = mem_we_q;

    // Selects are a pure function of the latched instruction while it is in
    // flight, so they hold steady from DECODE through WB and read 0 otherwise.
    assign active = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                    (state_q == ST_MEM)    || (state_q == ST_WB);

    always_comb begin
        pc_next_sel = 1'b0;
        pc_alu_sel  = 1'b0;
        alu_sel_a   = 1'b0;
        alu_sel_b   = 1'b0;
        addr_sel    = 1'b0;
        rd_sel      = RD_SEL_MEM;
        func        = FUNC_ADD;
        sub_sra     = 1'b0;
        if (active) begin
            case (cls)
                CLS_OP: begin
                    func    = insn[14:12];
                    sub_sra = insn[30];
                    rd_sel  = RD_SEL_ALU;
                end
                CLS_OP_IMM: begin
                    alu_sel_b = 1'b1;
                    func      = insn[14:12];
                    sub_sra   = (insn[14:12] == 3'b101) ? insn[30] : 1'b0;
                    rd_sel    = RD_SEL_ALU;
                end
                CLS_LOAD: begin
                    alu_sel_b = 1'b1;
                    addr_sel  = 1'b1;
                    rd_sel    = RD_SEL_MEM;
                end
                CLS_STORE: begin
                    alu_sel_b = 1'b1;
                    addr_sel  = 1'b1;
                end
                CLS_BRANCH: begin
                    func       = insn[14:12];
                    pc_alu_sel = branch_taken(insn[14:12], EQ, LS, LU);
                end
                CLS_AUIPC: begin
                    alu_sel_a = 1'b1;
                    alu_sel_b = 1'b1;
                    rd_sel    = RD_SEL_ALU;
                end
                CLS_JAL: begin
                    alu_sel_a   = 1'b1;
                    alu_sel_b   = 1'b1;
                    rd_sel      = RD_SEL_PC_INC;
                    pc_next_sel = 1'b1;
                end
                CLS_JALR: begin
                    alu_sel_b   = 1'b1;
                    rd_sel      = RD_SEL_PC_INC;
                    pc_next_sel = 1'b1;
                end
                CLS_LUI:  rd_sel = RD_SEL_IMM;
                default: ;
            endcase
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
